// File: rtl/mycpu_div_unit.sv
// rtl/mycpu_div_unit.sv - iterative radix-2 restoring divider with AXI-stream-like operand/result channels
module mycpu_div_unit #(
    parameter int SIGNED = 1,
    parameter int WIDTH  = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   dvd_q, dvs_q;
    logic               dvd_full, dvs_full;
    logic [WIDTH-1:0]   rem, quo, dvs_mag;
    logic               q_neg, r_neg, dvs_zero;
    logic [CW-1:0]      count;

    logic               dvd_hs, dvs_hs, start;
    logic [WIDTH-1:0]   dvd_op, dvs_op, dvd_abs, dvs_abs;
    logic               dvd_neg, dvs_neg;
    logic [WIDTH:0]     shifted, diff;
    logic               keep;
    logic [WIDTH-1:0]   rem_nx, quo_nx, q_fin, r_fin;

    assign s_axis_dividend_tready = (state == S_IDLE) & ~dvd_full & resetn;
    assign s_axis_divisor_tready  = (state == S_IDLE) & ~dvs_full & resetn;
    assign m_axis_dout_tvalid     = (state == S_DONE);

    assign dvd_hs = s_axis_dividend_tvalid & s_axis_dividend_tready;
    assign dvs_hs = s_axis_divisor_tvalid & s_axis_divisor_tready;
    // Operands handshaken on the starting edge bypass the holding registers.
    assign dvd_op = dvd_hs ? s_axis_dividend_tdata : dvd_q;
    assign dvs_op = dvs_hs ? s_axis_divisor_tdata : dvs_q;
    assign start  = (state == S_IDLE) & (dvd_full | dvd_hs) & (dvs_full | dvs_hs);

    assign dvd_neg = (SIGNED != 0) && dvd_op[WIDTH-1];
    assign dvs_neg = (SIGNED != 0) && dvs_op[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dvd_op : dvd_op;
    assign dvs_abs = dvs_neg ? -dvs_op : dvs_op;

    // Partial remainder is WIDTH+1 bits so the borrow bit marks a failed trial subtract.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_mag};
    assign keep    = ~diff[WIDTH];
    assign rem_nx  = keep ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nx  = {quo[WIDTH-2:0], keep};

    // Divide-by-zero keeps the all-ones quotient; negating |dividend| restores the dividend.
    assign q_fin = (q_neg & ~dvs_zero) ? -quo_nx : quo_nx;
    assign r_fin = r_neg ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= S_IDLE;
            dvd_q             <= '0;
            dvs_q             <= '0;
            dvd_full          <= 1'b0;
            dvs_full          <= 1'b0;
            rem               <= '0;
            quo               <= '0;
            dvs_mag           <= '0;
            q_neg             <= 1'b0;
            r_neg             <= 1'b0;
            dvs_zero          <= 1'b0;
            count             <= '0;
            m_axis_dout_tdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dvd_hs) begin
                        dvd_q    <= s_axis_dividend_tdata;
                        dvd_full <= 1'b1;
                    end
                    if (dvs_hs) begin
                        dvs_q    <= s_axis_divisor_tdata;
                        dvs_full <= 1'b1;
                    end
                    if (start) begin
                        state    <= S_CALC;
                        dvd_full <= 1'b0;
                        dvs_full <= 1'b0;
                        rem      <= '0;
                        quo      <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        q_neg    <= dvd_neg ^ dvs_neg;
                        r_neg    <= dvd_neg;
                        dvs_zero <= (dvs_op == '0);
                        count    <= '0;
                    end
                end
                S_CALC: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state             <= S_DONE;
                        m_axis_dout_tdata <= {q_fin, r_fin};
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
